// File: rtl/wb_exmem_bridge_pkg.sv
// Shared types and defaults for the Wishbone to exmem_pipeline bridge.
// Holds the FSM encoding, default window/error constants and the window decode helper.
package wb_exmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;
    localparam logic [31:0] DEF_ADDR_MASK = 32'hFFC0_0000;
    localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;

    function automatic logic addr_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/wb_exmem_bridge_if.sv
// Bus bundle between a Wishbone-classic master, the bridge and the exmem_pipeline memory.
// Handshake: WB transfer completes on the single cycle wbs_ack_o is high while cyc/stb are held;
// mem_stb is a one-cycle request and mem_ack a one-cycle completion carrying mem_dat_i.
interface wb_exmem_bridge_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        mem_stb;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_o;
    logic        mem_ack;
    logic [31:0] mem_dat_i;

    // The bridge itself.
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  mem_ack, mem_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output mem_stb, mem_we, mem_sel, mem_addr, mem_dat_o
    );

    // The surrounding environment: WB master plus memory.
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output mem_ack, mem_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  mem_stb, mem_we, mem_sel, mem_addr, mem_dat_o
    );

endinterface

// File: rtl/wb_exmem_bridge_wdt.sv
// Saturating watchdog counter for the bridge: synchronous clear, count enable,
// and an expire flag on the last allowed cycle (count == TIMEOUT-1).
module wb_exmem_bridge_wdt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Clear beats enable; the count parks at TIMEOUT instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CW'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_exmem_bridge.sv
// Wishbone-classic slave front end for the exmem_pipeline memory: window decode,
// single request issue, fixed-latency wait with watchdog, and draining of orphaned acks.
module wb_exmem_bridge
    import wb_exmem_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
    parameter int          ADDR_W    = 10,
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
    input  logic             clk,
    input  logic             rst,
    wb_exmem_bridge_if.slave bus,
    output logic             busy,
    output logic             timeout_err,
    output state_t           dbg_state
);

    state_t state, state_next;

    logic req;
    logic latch_req;
    logic issue_next;
    logic ack_next;
    logic rd_load;
    logic err_load;
    logic tmo_set;
    logic wdt_clr;
    logic wdt_en;
    logic wdt_expire;

    // Masking with the registered ack stops a held stb from re-requesting in the ack cycle.
    assign req = bus.wbs_cyc_i & bus.wbs_stb_i & ~bus.wbs_ack_o &
                 addr_hit(bus.wbs_adr_i, BASE_ADDR, ADDR_MASK);

    assign dbg_state = state;

    wb_exmem_bridge_wdt #(
        .TIMEOUT(TIMEOUT)
    ) u_wdt (
        .clk   (clk),
        .rst   (rst),
        .clr   (wdt_clr),
        .en    (wdt_en),
        .expire(wdt_expire)
    );

    always_comb begin
        state_next = state;
        latch_req  = 1'b0;
        issue_next = 1'b0;
        ack_next   = 1'b0;
        rd_load    = 1'b0;
        err_load   = 1'b0;
        tmo_set    = 1'b0;
        wdt_clr    = 1'b0;
        wdt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    latch_req  = 1'b1;
                    issue_next = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdt_clr    = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                wdt_en = 1'b1;
                // A real ack always wins over the watchdog and over an abort.
                if (bus.mem_ack) begin
                    ack_next   = bus.wbs_cyc_i;
                    rd_load    = bus.wbs_cyc_i & ~bus.mem_we;
                    state_next = ST_IDLE;
                end else if (wdt_expire) begin
                    ack_next   = 1'b1;
                    err_load   = ~bus.mem_we;
                    tmo_set    = 1'b1;
                    wdt_clr    = 1'b1;
                    state_next = ST_DRAIN;
                end else if (!bus.wbs_cyc_i) begin
                    wdt_clr    = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                wdt_en = 1'b1;
                if (bus.mem_ack || wdt_expire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= '0;
            bus.mem_stb   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_sel   <= '0;
            bus.mem_addr  <= '0;
            bus.mem_dat_o <= '0;
        end else begin
            state         <= state_next;
            busy          <= (state_next != ST_IDLE);
            bus.wbs_ack_o <= ack_next;
            bus.mem_stb   <= issue_next;
            if (latch_req) begin
                bus.mem_we    <= bus.wbs_we_i;
                bus.mem_sel   <= bus.wbs_sel_i;
                bus.mem_addr  <= {{(32 - ADDR_W){1'b0}}, bus.wbs_adr_i[ADDR_W+1:2]};
                bus.mem_dat_o <= bus.wbs_dat_i;
            end
            if (rd_load) begin
                bus.wbs_dat_o <= bus.mem_dat_i;
            end else if (err_load) begin
                bus.wbs_dat_o <= ERR_DATA;
            end
            if (tmo_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
